// File: rtl/swev_pkg.sv
// Shared definitions for the switch event decoder and the downstream
// queue-count state machine.
//  - EVT_* : event codes carried on evt_code (one per slide switch)
//  - state_e : press-tracking FSM states
//  - swev_is_onehot / swev_encode : helpers for the 4-bit debounced vector
package swev_pkg;

  localparam logic [1:0] EVT_M8  = 2'd3;  // bit3, -8 (drive)
  localparam logic [1:0] EVT_P12 = 2'd2;  // bit2, +12
  localparam logic [1:0] EVT_P8  = 2'd1;  // bit1, +8
  localparam logic [1:0] EVT_P4  = 2'd0;  // bit0, +4

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } state_e;

  // True when exactly one bit is set.
  function automatic logic swev_is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Index of the set bit; only meaningful for a one-hot input.
  function automatic logic [1:0] swev_encode(input logic [3:0] v);
    return {v[3] | v[2], v[3] | v[1]};
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit conditioner: two-flop synchroniser followed by a counter-based
// debouncer. A new level is accepted only after the synchronised input has
// differed from the current stable level for DEBOUNCE_CYCLES consecutive clocks.
// Ports:
//  clk_i    in  system clock
//  rst_ni   in  asynchronous active-low reset
//  sw_i     in  raw switch, asynchronous to clk_i
//  stable_o out debounced level (registered)
module sw_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic stable_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // Synchroniser for the asynchronous raw input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next-state: count consecutive mismatches, flip on the last one.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= CNT_ZERO;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/switch_event_decoder.sv
// Turns the four raw slide switches into clean single-cycle events for the
// queue-count state machine: per-bit synchronise + debounce, then a two-state
// FSM that emits one pulse per press and demands a full release before the next.
// Ports:
//  CLOCK_50  in  50 MHz system clock
//  RESET_N   in  asynchronous active-low reset
//  SW        in  raw switches (bit3 -8, bit2 +12, bit1 +8, bit0 +4)
//  evt_valid out one-cycle pulse: single-switch press accepted
//  evt_code  out index of the pressed switch, held until the next valid event
//  evt_err   out one-cycle pulse: accepted press had more than one switch high
//  sw_idle   out 1 while all debounced switches are low
module switch_event_decoder
  import swev_pkg::*;
#(
  parameter int unsigned NUM_SW          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [NUM_SW-1:0] SW,
  output logic              evt_valid,
  output logic [1:0]        evt_code,
  output logic              evt_err,
  output logic              sw_idle
);

  logic [NUM_SW-1:0] stable_v;

  state_e     state_q, state_d;
  logic       evt_valid_q, evt_valid_d;
  logic       evt_err_q, evt_err_d;
  logic [1:0] evt_code_q, evt_code_d;
  logic       sw_idle_q, sw_idle_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SW; gi++) begin : g_deb
      sw_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_deb (
        .clk_i   (CLOCK_50),
        .rst_ni  (RESET_N),
        .sw_i    (SW[gi]),
        .stable_o(stable_v[gi])
      );
    end
  endgenerate

  // Press FSM next-state and output decode.
  always_comb begin
    state_d     = state_q;
    evt_valid_d = 1'b0;
    evt_err_d   = 1'b0;
    evt_code_d  = evt_code_q;
    sw_idle_d   = (stable_v == {NUM_SW{1'b0}});
    case (state_q)
      S_IDLE: begin
        if (stable_v != {NUM_SW{1'b0}}) begin
          // Multi-hot presses only flag an error; the last good code is kept.
          if (swev_is_onehot(stable_v)) begin
            evt_valid_d = 1'b1;
            evt_code_d  = swev_encode(stable_v);
          end else begin
            evt_err_d = 1'b1;
          end
          state_d = S_HELD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HELD: begin
        // Any change while something is still held is ignored.
        if (stable_v == {NUM_SW{1'b0}}) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HELD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      evt_valid_q <= 1'b0;
      evt_err_q   <= 1'b0;
      evt_code_q  <= EVT_P4;
      sw_idle_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_err_q   <= evt_err_d;
      evt_code_q  <= evt_code_d;
      sw_idle_q   <= sw_idle_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_err   = evt_err_q;
  assign evt_code  = evt_code_q;
  assign sw_idle   = sw_idle_q;

endmodule
